// File: rtl/riscv_pkg.sv
// Shared types for the RV32 pipeline control blocks: hazard FSM states and
// the hard-wired zero register index.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_MDU = 2'd1,
    S_MEM = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG0 = 5'h00;

endpackage

// File: rtl/load_use_detect.sv
// Load-use compare: the ID instruction reads the register a load in EX is
// still fetching. x0 never creates a dependency.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       mem_read_e,
  input  logic [4:0] rd_addr_e,
  input  logic [4:0] rs1_addr_d,
  input  logic [4:0] rs2_addr_d,
  output logic       lduse
);

  assign lduse = mem_read_e && (rd_addr_e != REG0) &&
                 ((rd_addr_e == rs1_addr_d) || (rd_addr_e == rs2_addr_d));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: resolves memory wait states, multi-cycle
// MDU ops, taken-branch flushes and load-use bubbles; counts stalled cycles.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             MemReadE,
  input  logic [4:0]       RD_ADDR_E,
  input  logic [4:0]       RS1_ADDR_D,
  input  logic [4:0]       RS2_ADDR_D,
  input  logic             PCSrcE,
  input  logic             MduStartE,
  input  logic             MduDone,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             o_mdu_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int              TO_W    = $clog2(MDU_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

  hz_state_t       state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            lduse, memwait, mdubusy, mdu_exit, mdu_hit_to;

  load_use_detect u_lud (
    .mem_read_e (MemReadE),
    .rd_addr_e  (RD_ADDR_E),
    .rs1_addr_d (RS1_ADDR_D),
    .rs2_addr_d (RS2_ADDR_D),
    .lduse      (lduse)
  );

  // A pending memory wait freezes the MDU FSM: no exit is taken while MEM stalls.
  always_comb begin
    memwait    = MemReqM && !MemReadyM;
    mdu_hit_to = (state == S_MDU) && (to_cnt == TO_LAST);
    mdu_exit   = (state == S_MDU) && !memwait && (MduDone || mdu_hit_to);
    mdubusy    = (state == S_MDU) ? !mdu_exit : (MduStartE && !MduDone);
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    unique case (state)
      S_RUN, S_MEM: begin
        if (memwait) begin
          state_nxt = S_MEM;
        end else if (MduStartE && !MduDone) begin
          state_nxt  = S_MDU;
          to_cnt_nxt = '0;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_MDU: begin
        if (mdu_exit) begin
          state_nxt  = S_RUN;
          to_cnt_nxt = '0;
        end else if (to_cnt != TO_LAST) begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      default: begin
        state_nxt  = S_RUN;
        to_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    StallF        = 1'b0;
    StallD        = 1'b0;
    StallE        = 1'b0;
    StallM        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    FlushM        = 1'b0;
    FlushW        = 1'b0;
    o_mdu_timeout = 1'b0;
    if (i_rst_n) begin
      o_mdu_timeout = mdu_exit && !MduDone;
      if (memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (mdubusy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (PCSrcE) begin
        // The ID instruction is wrong-path, so a load-use hazard on it is moot.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lduse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_RUN;
      to_cnt      <= '0;
      o_stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (StallF && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle hazard vectors
// plus hand sequences for MDU, timeout, memory wait, saturation and reset.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,timeout}
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] LDUSE = 9'b110001000;
  localparam logic [8:0] BR    = 9'b000011000;
  localparam logic [8:0] MDU   = 9'b111000100;
  localparam logic [8:0] MEMW  = 9'b111100010;
  localparam logic [8:0] TMO   = 9'b000000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic MemReadE = 1'b0, PCSrcE = 1'b0, MduStartE = 1'b0, MduDone = 1'b0;
  logic MemReqM = 1'b0, MemReadyM = 1'b0;
  logic [4:0] RD_ADDR_E = '0, RS1_ADDR_D = '0, RS2_ADDR_D = '0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic o_mdu_timeout;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [8:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] rd, rs1, rs2;
    logic       pc, ms, md, mq, my;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .MemReadE(MemReadE), .RD_ADDR_E(RD_ADDR_E), .RS1_ADDR_D(RS1_ADDR_D),
    .RS2_ADDR_D(RS2_ADDR_D), .PCSrcE(PCSrcE), .MduStartE(MduStartE),
    .MduDone(MduDone), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .o_mdu_timeout(o_mdu_timeout), .o_stall_cnt(o_stall_cnt)
  );

  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, o_mdu_timeout};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic mr, input logic [4:0] rd, rs1, rs2,
                     input logic pc, ms, md, mq, my, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.pc = pc; v.ms = ms; v.md = md; v.mq = mq; v.my = my; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic cyc(input string name, input logic mr, input logic [4:0] rd, rs1, rs2,
                     input logic pc, ms, md, mq, my, input logic [8:0] exp);
    @(negedge clk);
    MemReadE = mr; RD_ADDR_E = rd; RS1_ADDR_D = rs1; RS2_ADDR_D = rs2;
    PCSrcE = pc; MduStartE = ms; MduDone = md; MemReqM = mq; MemReadyM = my;
    #1;
    check(name, 32'(obs), 32'(exp));
  endtask

  // Control-only cycle: register addresses held at zero.
  task automatic ctl(input string name, input logic pc, ms, md, mq, my, input logic [8:0] exp);
    cyc(name, 1'b0, 5'd0, 5'd0, 5'd0, pc, ms, md, mq, my, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    add("idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE);
    add("lduse_rs1",   1, 5'd5, 5'd5, 5'd1, 0, 0, 0, 0, 0, LDUSE);
    add("lduse_rs2",   1, 5'd7, 5'd2, 5'd7, 0, 0, 0, 0, 0, LDUSE);
    add("lduse_x0",    1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE);
    add("no_load",     0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, NONE);
    add("no_match",    1, 5'd9, 5'd8, 5'd10, 0, 0, 0, 0, 0, NONE);
    add("branch",      0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, BR);
    add("branch_ldu",  1, 5'd5, 5'd5, 5'd1, 1, 0, 0, 0, 0, BR);
    add("mdu_1cyc",    0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, NONE);
    add("mdu_1cyc_ld", 1, 5'd3, 5'd4, 5'd3, 0, 1, 1, 0, 0, LDUSE);
    add("mem_ready",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, NONE);

    // Reset holds all outputs low even with hazard-causing inputs present.
    MduStartE = 1'b1; MemReadE = 1'b1; RD_ADDR_E = 5'd5; RS1_ADDR_D = 5'd5;
    #3;
    check("reset_outs", 32'(obs), 32'(NONE));
    check("reset_cnt", 32'(o_stall_cnt), 32'd0);
    @(negedge clk);
    MduStartE = 1'b0; MemReadE = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i])
      cyc(tbl[i].name, tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
          tbl[i].pc, tbl[i].ms, tbl[i].md, tbl[i].mq, tbl[i].my, tbl[i].exp);
    ctl("tbl_tail", 0, 0, 0, 0, 0, NONE);
    check("cnt_after_tbl", 32'(o_stall_cnt), 32'd3);

    // lduse releases after exactly one bubble once the load leaves EX
    cyc("ldu_c0", 1, 5'd5, 5'd6, 5'd5, 0, 0, 0, 0, 0, LDUSE);
    cyc("ldu_c1", 0, 5'd6, 5'd6, 5'd5, 0, 0, 0, 0, 0, NONE);

    // MDU finishing at cycle 4, with a taken branch suppressed mid-stall
    do_reset();
    ctl("mdu_c0", 0, 1, 0, 0, 0, MDU);
    ctl("mdu_c1", 0, 1, 0, 0, 0, MDU);
    ctl("mdu_c2_br", 1, 1, 0, 0, 0, MDU);
    ctl("mdu_c3", 0, 1, 0, 0, 0, MDU);
    ctl("mdu_c4_done", 0, 1, 1, 0, 0, NONE);
    ctl("mdu_c5_run", 0, 0, 0, 0, 0, NONE);
    check("cnt_mdu", 32'(o_stall_cnt), 32'd4);

    // MDU never completes: forced exit at cycle 8
    for (int i = 0; i < 8; i++) ctl($sformatf("to_c%0d", i), 0, 1, 0, 0, 0, MDU);
    ctl("to_c8_pulse", 0, 1, 0, 0, 0, TMO);
    ctl("to_c9_run", 0, 0, 0, 0, 0, NONE);
    check("cnt_to", 32'(o_stall_cnt), 32'd12);

    // Memory wait 3 cycles with a held taken branch flushing on release
    for (int i = 0; i < 3; i++) ctl($sformatf("mem_c%0d", i), 1, 0, 0, 1, 0, MEMW);
    ctl("mem_c3_rel_br", 1, 0, 0, 1, 1, BR);
    ctl("mem_c4_run", 0, 0, 0, 0, 0, NONE);
    check("cnt_at_max", 32'(o_stall_cnt), 32'd15);

    // Memory wait arising inside S_MDU: MEM wins, MDU stall resumes after
    ctl("mm_c0", 0, 1, 0, 0, 0, MDU);
    ctl("mm_c1", 0, 1, 0, 0, 0, MDU);
    ctl("mm_c2_mem", 0, 1, 0, 1, 0, MEMW);
    ctl("mm_c3_mem", 0, 1, 0, 1, 0, MEMW);
    ctl("mm_c4_mdu", 0, 1, 0, 1, 1, MDU);
    ctl("mm_c5_done", 0, 1, 1, 0, 0, NONE);
    ctl("mm_c6_run", 0, 0, 0, 0, 0, NONE);
    check("cnt_saturated", 32'(o_stall_cnt), 32'd15);

    // Reset asserted mid-cycle while in S_MDU
    ctl("rm_c0", 0, 1, 0, 0, 0, MDU);
    ctl("rm_c1", 0, 1, 0, 0, 0, MDU);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mdu_outs", 32'(obs), 32'(NONE));
    check("rst_mdu_cnt", 32'(o_stall_cnt), 32'd0);
    @(negedge clk);
    MduStartE = 1'b0;
    rst_n = 1'b1;
    ctl("post_rst_run", 0, 0, 0, 0, 0, NONE);
    ctl("post_rst_mdu", 0, 1, 0, 0, 0, MDU);
    ctl("post_rst_done", 0, 1, 1, 0, 0, NONE);
    ctl("post_rst_idle", 0, 0, 0, 0, 0, NONE);
    check("cnt_post_rst", 32'(o_stall_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
